// File: rtl/bcd_seq_converter_if.sv
// Valid/ready bundle between a binary producer and a BCD consumer.
// master: drives in_valid/binary_in/out_ready; slave: the converter.
interface bcd_seq_converter_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      binary_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  busy;

   modport master (
      output in_valid,
      output binary_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bcd_out,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  binary_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bcd_out,
      output busy
   );
endinterface

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Ports: clk, rst (async active-high), bus (slave side of the handshake).
module bcd_seq_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   bcd_seq_converter_if.slave   bus
);
   localparam int BW = 4 * DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state_q;
   logic [SW-1:0]    scratch_q;
   logic [SW-1:0]    scratch_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [BW-1:0]    bcd_q;
   logic [BW-1:0]    corr;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   // Add-3 on the pre-shift digits, then one shift of the whole scratch.
   // Digits are independent nibbles: a corrected digit is at most 12,
   // so no carry can cross into its neighbour.
   always_comb begin
      corr = scratch_q[SW-1:WIDTH];
      for (int d = 0; d < DIGITS; d++) begin
         if (corr[4*d +: 4] >= 4'd5) begin
            corr[4*d +: 4] = corr[4*d +: 4] + 4'd3;
         end
      end
      scratch_d = {corr, scratch_q[WIDTH-1:0]} << 1;
      cnt_d     = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         scratch_q   <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  scratch_q  <= {{BW{1'b0}}, bus.binary_in};
                  cnt_q      <= '0;
                  state_q    <= SHIFT;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            SHIFT: begin
               scratch_q <= scratch_d;
               cnt_q     <= cnt_d;
               if (cnt_d == LAST) begin
                  bcd_q       <= scratch_d[SW-1:WIDTH];
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.bcd_out   = bcd_q;
endmodule
